// File: rtl/temp_sample_ctrl_pkg.sv
// Shared definitions for the temperature sample controller.
//   temp_t        8-bit unsigned temperature in degrees
//   ctrl_state_t  sequencer states
//   CFG_TH_*      cfg_sel encodings for the two threshold registers
//   hi_clear_level / lo_clear_level  alarm release levels with hysteresis,
//                 worked at 9 bits and saturated at 0 / 255
package temp_sample_ctrl_pkg;

   typedef logic [7:0] temp_t;

   typedef enum logic [2:0] {
      IDLE,
      WAIT,
      REQ,
      CAPTURE,
      EVAL
   } ctrl_state_t;

   localparam logic CFG_TH_HI = 1'b0;
   localparam logic CFG_TH_LO = 1'b1;

   // Level below which a high alarm releases; never goes negative.
   function automatic logic [8:0] hi_clear_level(input temp_t th, input logic [8:0] hyst);
      logic [8:0] th9;
      th9 = {1'b0, th};
      return (th9 >= hyst) ? (th9 - hyst) : 9'd0;
   endfunction

   // Level above which a low alarm releases; clipped to the 8-bit range.
   // The sum fits in 9 bits as long as the hysteresis is below 256.
   function automatic logic [8:0] lo_clear_level(input temp_t th, input logic [8:0] hyst);
      logic [8:0] sum9;
      sum9 = {1'b0, th} + hyst;
      return (sum9 > 9'd255) ? 9'd255 : sum9;
   endfunction

endpackage

// File: rtl/temp_sample_ctrl_sample_timer.sv
// Timing helper for the sample sequencer.
//   clk, reset     clock and asynchronous active-low reset
//   run            period counter runs while high, held at 0 while low
//   wrap           high in the last cycle of every period
//   to_clear       restart the response timeout (asserted in the request cycle)
//   to_run         advance the timeout counter (asserted while waiting for data)
//   to_expired     high in the last cycle the sensor may still answer
module sample_timer #(
   parameter int PERIOD  = 1000,
   parameter int TIMEOUT = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic run,
   input  logic to_clear,
   input  logic to_run,
   output logic wrap,
   output logic to_expired
);

   localparam int PW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [PW-1:0] PER_LAST = PW'(PERIOD - 1);
   localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);

   logic [PW-1:0] per_cnt;
   logic [TW-1:0] to_cnt;

   // Free-running period counter; it keeps wrapping while the loop is active
   // so requests stay evenly spaced no matter how long a capture takes.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         per_cnt <= '0;
      end else if (!run || per_cnt == PER_LAST) begin
         per_cnt <= '0;
      end else begin
         per_cnt <= per_cnt + PW'(1);
      end
   end

   assign wrap = run && (per_cnt == PER_LAST);

   // The timeout counter holds the number of cycles elapsed since the request.
   // The request cycle itself is cycle 0, so a clear loads 1 for the next cycle,
   // and the count saturates at its last legal value.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         to_cnt <= '0;
      end else if (to_clear) begin
         to_cnt <= TW'(1);
      end else if (to_run && !to_expired) begin
         to_cnt <= to_cnt + TW'(1);
      end
   end

   assign to_expired = (to_cnt == TO_LAST);

endmodule

// File: rtl/temp_sample_ctrl.sv
// Temperature sensor sequencer: periodic sample requests, averaging of
// 2**AVG_LOG2 readings, hysteretic high/low alarms and a sticky timeout fault.
//   clk, reset        clock and asynchronous active-low reset
//   enable            run the sampling loop; low parks the sequencer in IDLE
//   sample_req        one-cycle request pulse to the sensor
//   sample_valid      sensor reading strobe, sample_temp carries the value
//   cfg_we/cfg_sel    threshold write (0 = high threshold, 1 = low threshold)
//   cfg_wdata         threshold value
//   avg_temp          last completed average, avg_valid pulses when it updates
//   alarm_hi/alarm_lo over/under temperature flags
//   sensor_fault      sticky flag, set on a response timeout, cleared by cfg_we
module temp_sample_ctrl
   import temp_sample_ctrl_pkg::*;
#(
   parameter int SAMPLE_PERIOD = 1000,
   parameter int TIMEOUT       = 16,
   parameter int AVG_LOG2      = 3,
   parameter int HYST          = 4,
   parameter int TH_HI_RST     = 200,
   parameter int TH_LO_RST     = 20
) (
   input  logic  clk,
   input  logic  reset,
   input  logic  enable,
   output logic  sample_req,
   input  logic  sample_valid,
   input  temp_t sample_temp,
   input  logic  cfg_we,
   input  logic  cfg_sel,
   input  temp_t cfg_wdata,
   output temp_t avg_temp,
   output logic  avg_valid,
   output logic  alarm_hi,
   output logic  alarm_lo,
   output logic  sensor_fault
);

   localparam int AW = 8 + AVG_LOG2;
   localparam int CW = AVG_LOG2 + 1;
   localparam logic [CW-1:0] N_SAMPLES = CW'(1 << AVG_LOG2);
   localparam logic [8:0]    HYST9     = 9'(HYST);

   ctrl_state_t   state, state_next;
   logic [AW-1:0] acc;
   logic [CW-1:0] cnt;
   temp_t         th_hi, th_lo;
   logic          wrap, to_expired;

   logic [AW-1:0] acc_sum;
   logic [CW-1:0] cnt_inc;
   logic          take, last, timeout;
   temp_t         avg_next, th_hi_use, th_lo_use;
   logic [8:0]    avg9;
   logic          hi_next, lo_next;

   sample_timer #(
      .PERIOD  (SAMPLE_PERIOD),
      .TIMEOUT (TIMEOUT)
   ) u_timer (
      .clk        (clk),
      .reset      (reset),
      .run        (enable && (state != IDLE)),
      .to_clear   (state == REQ),
      .to_run     (state == CAPTURE),
      .wrap       (wrap),
      .to_expired (to_expired)
   );

   // Datapath decode. The final reading of a batch updates the results on the
   // same edge that enters EVAL, so they are visible together with avg_valid.
   assign acc_sum  = acc + AW'(sample_temp);
   assign cnt_inc  = cnt + CW'(1);
   assign take     = enable && (state == CAPTURE) && sample_valid;
   assign last     = take && (cnt_inc == N_SAMPLES);
   assign timeout  = enable && (state == CAPTURE) && !sample_valid && to_expired;
   assign avg_next = acc_sum[AW-1:AVG_LOG2];
   assign avg9     = {1'b0, avg_next};

   // A threshold written in the final capture cycle is forwarded so it counts
   // for the evaluation happening on that same edge.
   assign th_hi_use = (cfg_we && cfg_sel == CFG_TH_HI) ? cfg_wdata : th_hi;
   assign th_lo_use = (cfg_we && cfg_sel == CFG_TH_LO) ? cfg_wdata : th_lo;

   // Alarm decisions: set at the threshold, release only past the hysteresis band.
   always_comb begin
      hi_next = alarm_hi;
      lo_next = alarm_lo;
      if (avg9 >= {1'b0, th_hi_use}) begin
         hi_next = 1'b1;
      end else if (avg9 < hi_clear_level(th_hi_use, HYST9)) begin
         hi_next = 1'b0;
      end
      if (avg9 <= {1'b0, th_lo_use}) begin
         lo_next = 1'b1;
      end else if (avg9 > lo_clear_level(th_lo_use, HYST9)) begin
         lo_next = 1'b0;
      end
   end

   // Sequencer state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic; dropping enable parks the sequencer from any state.
   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:    state_next = WAIT;
         WAIT:    if (wrap) state_next = REQ;
         REQ:     state_next = CAPTURE;
         CAPTURE: begin
            if (sample_valid) begin
               state_next = (cnt_inc == N_SAMPLES) ? EVAL : WAIT;
            end else if (to_expired) begin
               state_next = WAIT;
            end
         end
         EVAL:    state_next = WAIT;
         default: state_next = IDLE;
      endcase
      if (!enable) begin
         state_next = IDLE;
      end
   end

   // State-decoded strobes.
   always_comb begin
      sample_req = 1'b0;
      avg_valid  = 1'b0;
      if (state == REQ) begin
         sample_req = 1'b1;
      end
      if (state == EVAL) begin
         avg_valid = 1'b1;
      end
   end

   // Accumulator and sample count. A timed-out sample leaves both untouched;
   // a disable or a finished batch clears them.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         acc <= '0;
         cnt <= '0;
      end else if (!enable || state == EVAL) begin
         acc <= '0;
         cnt <= '0;
      end else if (take) begin
         acc <= acc_sum;
         cnt <= cnt_inc;
      end
   end

   // Published average and alarms only change when a full batch completes.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         avg_temp <= '0;
         alarm_hi <= 1'b0;
         alarm_lo <= 1'b0;
      end else if (last) begin
         avg_temp <= avg_next;
         alarm_hi <= hi_next;
         alarm_lo <= lo_next;
      end
   end

   // Threshold registers, writable in any state.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         th_hi <= 8'(TH_HI_RST);
         th_lo <= 8'(TH_LO_RST);
      end else if (cfg_we) begin
         if (cfg_sel == CFG_TH_HI) begin
            th_hi <= cfg_wdata;
         end else begin
            th_lo <= cfg_wdata;
         end
      end
   end

   // Sticky fault: a timeout takes priority over a simultaneous clearing write.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sensor_fault <= 1'b0;
      end else if (timeout) begin
         sensor_fault <= 1'b1;
      end else if (cfg_we) begin
         sensor_fault <= 1'b0;
      end
   end

endmodule

// File: tb/tb_temp_sample_ctrl.sv
// Self-checking bench for temp_sample_ctrl with SAMPLE_PERIOD=20, TIMEOUT=16,
// AVG_LOG2=2, HYST=4 and default thresholds 200/20. Inputs change and outputs
// are sampled on the falling clock edge.
module tb_temp_sample_ctrl;

   localparam int PERIOD = 20;

   logic       clk = 1'b0;
   logic       reset;
   logic       enable;
   logic       sample_req;
   logic       sample_valid;
   logic [7:0] sample_temp;
   logic       cfg_we;
   logic       cfg_sel;
   logic [7:0] cfg_wdata;
   logic [7:0] avg_temp;
   logic       avg_valid;
   logic       alarm_hi;
   logic       alarm_lo;
   logic       sensor_fault;

   int checks     = 0;
   int errors     = 0;
   int avg_pulses = 0;

   typedef struct {
      logic [31:0] rd;
      logic [7:0]  exp_avg;
      logic        exp_hi;
      logic        exp_lo;
   } vec_t;

   vec_t vecs[10];

   temp_sample_ctrl #(
      .SAMPLE_PERIOD (PERIOD),
      .TIMEOUT       (16),
      .AVG_LOG2      (2),
      .HYST          (4),
      .TH_HI_RST     (200),
      .TH_LO_RST     (20)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .enable       (enable),
      .sample_req   (sample_req),
      .sample_valid (sample_valid),
      .sample_temp  (sample_temp),
      .cfg_we       (cfg_we),
      .cfg_sel      (cfg_sel),
      .cfg_wdata    (cfg_wdata),
      .avg_temp     (avg_temp),
      .avg_valid    (avg_valid),
      .alarm_hi     (alarm_hi),
      .alarm_lo     (alarm_lo),
      .sensor_fault (sensor_fault)
   );

   always #5 clk = ~clk;

   // Count every average pulse so stretches of "no average expected" can be checked.
   always @(negedge clk) begin
      if (avg_valid) avg_pulses++;
   end

   // Hard stop in case something stalls beyond every bounded wait.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got no finish, expected finish before 500000");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic vec_t mk(input logic [7:0] a, b, c, d, avg, input logic hi, lo);
      vec_t v;
      v.rd      = {d, c, b, a};
      v.exp_avg = avg;
      v.exp_hi  = hi;
      v.exp_lo  = lo;
      return v;
   endfunction

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
      end
   endtask

   // Step falling edges until sample_req is seen; a missing request is a failure.
   task automatic waitReq();
      int  n;
      bit  seen;
      n    = 0;
      seen = 1'b0;
      while (!seen && n < 3 * PERIOD) begin
         @(negedge clk);
         n++;
         if (sample_req) seen = 1'b1;
      end
      if (!seen) checkOutput("req_timeout", 0, 1);
   endtask

   // Called in the request cycle: answer in the following (capture) cycle.
   task automatic replyNow(input logic [7:0] t);
      @(negedge clk);
      sample_valid = 1'b1;
      sample_temp  = t;
      @(negedge clk);
      sample_valid = 1'b0;
   endtask

   task automatic applyStimulus(input logic [7:0] t);
      waitReq();
      replyNow(t);
   endtask

   initial begin
      int n;
      int pulses0;

      // Readings are listed in arrival order.
      vecs[0] = mk(8'd100, 8'd101, 8'd102, 8'd103, 8'd101, 1'b0, 1'b0);
      vecs[1] = mk(8'd200, 8'd200, 8'd200, 8'd200, 8'd200, 1'b1, 1'b0);
      vecs[2] = mk(8'd197, 8'd197, 8'd197, 8'd197, 8'd197, 1'b1, 1'b0);
      vecs[3] = mk(8'd195, 8'd195, 8'd195, 8'd195, 8'd195, 1'b0, 1'b0);
      vecs[4] = mk(8'd20,  8'd20,  8'd20,  8'd20,  8'd20,  1'b0, 1'b1);
      vecs[5] = mk(8'd24,  8'd24,  8'd24,  8'd24,  8'd24,  1'b0, 1'b1);
      vecs[6] = mk(8'd25,  8'd25,  8'd25,  8'd25,  8'd25,  1'b0, 1'b0);
      vecs[7] = mk(8'd10,  8'd10,  8'd10,  8'd11,  8'd10,  1'b0, 1'b1);
      vecs[8] = mk(8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 1'b1, 1'b0);
      vecs[9] = mk(8'd0,   8'd0,   8'd0,   8'd3,   8'd0,   1'b0, 1'b1);

      reset        = 1'b0;
      enable       = 1'b0;
      sample_valid = 1'b0;
      sample_temp  = 8'd0;
      cfg_we       = 1'b0;
      cfg_sel      = 1'b0;
      cfg_wdata    = 8'd0;

      repeat (3) @(negedge clk);
      checkOutput("rst_sample_req", sample_req, 0);
      checkOutput("rst_avg_valid", avg_valid, 0);
      checkOutput("rst_avg_temp", avg_temp, 0);
      checkOutput("rst_alarm_hi", alarm_hi, 0);
      checkOutput("rst_alarm_lo", alarm_lo, 0);
      checkOutput("rst_fault", sensor_fault, 0);
      reset  = 1'b1;
      enable = 1'b1;

      // Averaging and alarm table with the reset thresholds.
      for (int v = 0; v < 10; v++) begin
         for (int k = 0; k < 4; k++) begin
            waitReq();
            @(negedge clk);
            if (k == 3) checkOutput("avg_valid_early", avg_valid, 0);
            sample_valid = 1'b1;
            sample_temp  = vecs[v].rd[8*k +: 8];
            @(negedge clk);
            sample_valid = 1'b0;
         end
         checkOutput($sformatf("vec%0d_avg_valid", v), avg_valid, 1);
         checkOutput($sformatf("vec%0d_avg_temp", v), avg_temp, vecs[v].exp_avg);
         checkOutput($sformatf("vec%0d_alarm_hi", v), alarm_hi, vecs[v].exp_hi);
         checkOutput($sformatf("vec%0d_alarm_lo", v), alarm_lo, vecs[v].exp_lo);
         @(negedge clk);
         checkOutput($sformatf("vec%0d_avg_pulse_width", v), avg_valid, 0);
      end

      // Silent sensor: pulse width, fault timing and request spacing.
      waitReq();
      for (n = 1; n <= PERIOD; n++) begin
         @(negedge clk);
         if (n == 1)      checkOutput("req_width", sample_req, 0);
         if (n == 15)     checkOutput("fault_before_timeout", sensor_fault, 0);
         if (n == 16)     checkOutput("fault_at_timeout", sensor_fault, 1);
         if (n == PERIOD) checkOutput("req_spacing", sample_req, 1);
      end

      // Clear the fault with a high-threshold write of 180, then prove 180 is used.
      cfg_we    = 1'b1;
      cfg_sel   = 1'b0;
      cfg_wdata = 8'd180;
      @(negedge clk);
      cfg_we       = 1'b0;
      checkOutput("fault_cleared", sensor_fault, 0);
      sample_valid = 1'b1;
      sample_temp  = 8'd185;
      @(negedge clk);
      sample_valid = 1'b0;
      repeat (3) applyStimulus(8'd185);
      checkOutput("th180_avg_valid", avg_valid, 1);
      checkOutput("th180_avg_temp", avg_temp, 185);
      checkOutput("th180_alarm_hi", alarm_hi, 1);
      checkOutput("th180_alarm_lo", alarm_lo, 0);

      // Partial batch, then drop enable during a request; the late reply is ignored.
      applyStimulus(8'd90);
      waitReq();
      enable = 1'b0;
      pulses0 = avg_pulses;
      @(negedge clk);
      checkOutput("dis_req_done", sample_req, 0);
      sample_valid = 1'b1;
      sample_temp  = 8'd50;
      @(negedge clk);
      sample_valid = 1'b0;
      repeat (5) @(negedge clk);
      checkOutput("dis_no_avg", avg_pulses - pulses0, 0);
      checkOutput("dis_avg_hold", avg_temp, 185);
      checkOutput("dis_hi_hold", alarm_hi, 1);
      checkOutput("dis_lo_hold", alarm_lo, 0);

      // Re-enable: first request one idle cycle plus a full period later.
      enable = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!sample_req && n < 3 * PERIOD);
      checkOutput("reenable_req_delay", n, PERIOD + 1);
      replyNow(8'd10);
      repeat (3) applyStimulus(8'd10);
      checkOutput("reen_avg_valid", avg_valid, 1);
      checkOutput("reen_avg_temp", avg_temp, 10);
      checkOutput("reen_alarm_hi", alarm_hi, 0);
      checkOutput("reen_alarm_lo", alarm_lo, 1);

      // Reset in the middle of a capture with a partial sum held.
      applyStimulus(8'd100);
      waitReq();
      @(negedge clk);
      reset = 1'b0;
      #1;
      checkOutput("midrst_avg_temp", avg_temp, 0);
      checkOutput("midrst_alarm_lo", alarm_lo, 0);
      checkOutput("midrst_alarm_hi", alarm_hi, 0);
      checkOutput("midrst_fault", sensor_fault, 0);
      checkOutput("midrst_sample_req", sample_req, 0);
      checkOutput("midrst_avg_valid", avg_valid, 0);
      @(negedge clk);
      reset = 1'b1;
      pulses0 = avg_pulses;
      repeat (3) applyStimulus(8'd190);
      checkOutput("midrst_no_partial", avg_pulses - pulses0, 0);
      applyStimulus(8'd190);
      checkOutput("post_rst_avg_valid", avg_valid, 1);
      checkOutput("post_rst_avg_temp", avg_temp, 190);
      checkOutput("post_rst_alarm_hi", alarm_hi, 0);
      checkOutput("post_rst_alarm_lo", alarm_lo, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
